// File: rtl/csr_defs.sv
// Shared CSR/MMIO definitions: CLINT register offsets, per-hart strides
// and the byte-lane merge helper used by every byte-enable write path.
package csr_defs;

  // Byte offsets inside the 64 KiB CLINT window.
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  // Address distance between consecutive harts' registers.
  localparam int CLINT_MSIP_STRIDE     = 4;
  localparam int CLINT_MTIMECMP_STRIDE = 8;

  // Replace each byte lane of old_word whose enable is set with the
  // matching lane of new_word.
  function automatic logic [31:0] be_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_timebase.sv
// CLINT timebase: clock prescaler feeding a free-running 64-bit mtime
// counter with a word-wise software write port and a debug freeze.
module clint_timebase
  import csr_defs::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_halt,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [63:0]      mtime_reg;
  logic             tick;

  // With TICK_DIV = 1 the counter sits at 0 == DIV_LAST, so every
  // non-halted cycle ticks.
  assign tick  = !dbg_halt && (div_cnt_reg == DIV_LAST);
  assign mtime = mtime_reg;

  // Prescaler: counts non-halted cycles, wrapping after TICK_DIV of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (!dbg_halt) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  // mtime: a software write to either word suppresses that cycle's
  // increment entirely, so no carry leaks into the unwritten word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_reg <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) begin
        mtime_reg[31:0] <= be_merge(mtime_reg[31:0], wr_data, wr_be);
      end
      if (wr_hi) begin
        mtime_reg[63:32] <= be_merge(mtime_reg[63:32], wr_data, wr_be);
      end
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

endmodule

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: MMIO decode, per-hart msip and
// mtimecmp registers, registered mtip compare and a one-cycle response.
module clint_multi
  import csr_defs::*;
#(
  parameter int          NUM_HARTS = 1,
  parameter int          TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [3:0]           req_be,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  input  logic                 dbg_halt,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] mtip
);

  localparam logic [13:0] MTIME_LO_WORD = 14'(CLINT_MTIME_OFF >> 2);
  localparam logic [13:0] MTIME_HI_WORD = 14'((CLINT_MTIME_OFF + 16'd4) >> 2);

  logic [31:0]          rel_addr;
  logic [13:0]          word_off;
  logic                 in_window;
  logic                 addr_lsb_unused;
  logic                 wr_en;
  logic [NUM_HARTS-1:0] msip_sel;
  logic [NUM_HARTS-1:0] cmp_lo_sel;
  logic [NUM_HARTS-1:0] cmp_hi_sel;
  logic                 mtime_lo_sel;
  logic                 mtime_hi_sel;
  logic                 hit;
  logic                 msip_reg [NUM_HARTS];
  logic                 mtip_reg [NUM_HARTS];
  logic [63:0]          mtimecmp_reg [NUM_HARTS];
  logic [63:0]          mtime;
  logic [31:0]          rdata_next;
  logic                 rsp_valid_reg;
  logic                 rsp_err_reg;
  logic [31:0]          rsp_rdata_reg;

  // Window-relative word offset; byte bits [1:0] are deliberately ignored.
  assign rel_addr        = req_addr - BASE_ADDR;
  assign word_off        = rel_addr[15:2];
  assign in_window       = (rel_addr[31:16] == 16'h0);
  assign addr_lsb_unused = ^rel_addr[1:0];
  assign wr_en           = req_valid && req_we;

  assign mtime_lo_sel = in_window && (word_off == MTIME_LO_WORD);
  assign mtime_hi_sel = in_window && (word_off == MTIME_HI_WORD);
  assign hit = in_window && ((|msip_sel) || (|cmp_lo_sel) || (|cmp_hi_sel) ||
                             mtime_lo_sel || mtime_hi_sel);

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    assign msip_sel[gi]   = in_window && (word_off ==
      14'((32'(CLINT_MSIP_OFF) + CLINT_MSIP_STRIDE * gi) >> 2));
    assign cmp_lo_sel[gi] = in_window && (word_off ==
      14'((32'(CLINT_MTIMECMP_OFF) + CLINT_MTIMECMP_STRIDE * gi) >> 2));
    assign cmp_hi_sel[gi] = in_window && (word_off ==
      14'((32'(CLINT_MTIMECMP_OFF) + CLINT_MTIMECMP_STRIDE * gi + 4) >> 2));

    assign msip[gi] = msip_reg[gi];
    assign mtip[gi] = mtip_reg[gi];

    // msip: only bit 0 exists, so only byte lane 0 can change it.
    always_ff @(posedge clk) begin
      if (rst) begin
        msip_reg[gi] <= 1'b0;
      end else if (wr_en && msip_sel[gi] && req_be[0]) begin
        msip_reg[gi] <= req_wdata[0];
      end
    end

    // mtimecmp: resets to all-ones so no timer interrupt is pending.
    always_ff @(posedge clk) begin
      if (rst) begin
        mtimecmp_reg[gi] <= '1;
      end else begin
        if (wr_en && cmp_lo_sel[gi]) begin
          mtimecmp_reg[gi][31:0] <= be_merge(mtimecmp_reg[gi][31:0], req_wdata, req_be);
        end
        if (wr_en && cmp_hi_sel[gi]) begin
          mtimecmp_reg[gi][63:32] <= be_merge(mtimecmp_reg[gi][63:32], req_wdata, req_be);
        end
      end
    end

    // mtip: registered unsigned compare, one cycle behind the registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        mtip_reg[gi] <= 1'b0;
      end else begin
        mtip_reg[gi] <= (mtime >= mtimecmp_reg[gi]);
      end
    end
  end

  // A write with no byte enables is a pure no-op and must not steal a tick.
  clint_timebase #(
    .TICK_DIV (TICK_DIV)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .dbg_halt (dbg_halt),
    .wr_lo    (wr_en && mtime_lo_sel && (req_be != 4'b0)),
    .wr_hi    (wr_en && mtime_hi_sel && (req_be != 4'b0)),
    .wr_be    (req_be),
    .wr_data  (req_wdata),
    .mtime    (mtime)
  );

  // Read mux: unmapped offsets fall through to zero.
  always_comb begin
    rdata_next = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_sel[h])   rdata_next = {31'b0, msip_reg[h]};
      if (cmp_lo_sel[h]) rdata_next = mtimecmp_reg[h][31:0];
      if (cmp_hi_sel[h]) rdata_next = mtimecmp_reg[h][63:32];
    end
    if (mtime_lo_sel) rdata_next = mtime[31:0];
    if (mtime_hi_sel) rdata_next = mtime[63:32];
  end

  // Response register: one strobe per accepted request, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= req_valid;
      rsp_err_reg   <= req_valid && !hit;
      rsp_rdata_reg <= (req_valid && !req_we) ? rdata_next : '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: two instances (2 harts / TICK_DIV 4 and
// 1 hart / TICK_DIV 1) on a shared request bus, checked every cycle
// against a behavioural model of the register map and timebase.
module tb_clint_multi;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, dbg_halt;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rsp_valid_a, rsp_err_a, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic [1:0]  msip_a, mtip_a;
  logic [0:0]  msip_b, mtip_b;

  always #5 clk = ~clk;

  clint_multi #(.NUM_HARTS(2), .TICK_DIV(4), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .dbg_halt(dbg_halt), .msip(msip_a), .mtip(mtip_a)
  );

  clint_multi #(.NUM_HARTS(1), .TICK_DIV(1), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .dbg_halt(dbg_halt), .msip(msip_b), .mtip(mtip_b)
  );

  // Behavioural model, index 0 = dut_a, 1 = dut_b.
  logic [63:0]     m_time [2];
  longint unsigned m_run  [2];
  logic [63:0]     m_cmp  [2][2];
  bit              m_msip [2][2];
  bit              m_mtip [2][2];

  int checks = 0;
  int errors = 0;

  function automatic int harts_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [31:0] lane_update(logic [31:0] cur, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Returns {err, rdata} for a read of addr against the model state.
  function automatic logic [32:0] model_read(int i, logic [31:0] addr);
    int off, h;
    off = int'(addr[15:0]) & 'hFFFC;
    if (off < 'h4000) begin
      h = off / 4;
      if (h < harts_of(i)) return {1'b0, 31'b0, m_msip[i][h]};
    end else if (off < 'hBFF8) begin
      h = (off - 'h4000) / 8;
      if (h < harts_of(i)) return (off % 8 == 0) ? {1'b0, m_cmp[i][h][31:0]}
                                                   : {1'b0, m_cmp[i][h][63:32]};
    end else if (off == 'hBFF8) begin
      return {1'b0, m_time[i][31:0]};
    end else if (off == 'hBFFC) begin
      return {1'b0, m_time[i][63:32]};
    end
    return {1'b1, 32'b0};
  endfunction

  // Advance the model by one clock edge using the inputs presented now.
  task automatic model_update();
    bit tick, twr;
    int off, h;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_time[i] = '0;
        m_run[i]  = 0;
        for (int k = 0; k < 2; k++) begin
          m_cmp[i][k]  = '1;
          m_msip[i][k] = 1'b0;
          m_mtip[i][k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < harts_of(i); k++) m_mtip[i][k] = (m_time[i] >= m_cmp[i][k]);
        tick = !dbg_halt && (m_run[i] % longint'(div_of(i)) == longint'(div_of(i) - 1));
        if (!dbg_halt) m_run[i]++;
        twr = 1'b0;
        if (req_valid && req_we) begin
          off = int'(req_addr[15:0]) & 'hFFFC;
          if (off < 'h4000) begin
            h = off / 4;
            if (h < harts_of(i) && req_be[0]) m_msip[i][h] = req_wdata[0];
          end else if (off < 'hBFF8) begin
            h = (off - 'h4000) / 8;
            if (h < harts_of(i)) begin
              if (off % 8 == 0) m_cmp[i][h][31:0]  = lane_update(m_cmp[i][h][31:0], req_wdata, req_be);
              else              m_cmp[i][h][63:32] = lane_update(m_cmp[i][h][63:32], req_wdata, req_be);
            end
          end else if (off == 'hBFF8 && req_be != 4'b0) begin
            m_time[i][31:0] = lane_update(m_time[i][31:0], req_wdata, req_be);
            twr = 1'b1;
          end else if (off == 'hBFFC && req_be != 4'b0) begin
            m_time[i][63:32] = lane_update(m_time[i][63:32], req_wdata, req_be);
            twr = 1'b1;
          end
        end
        if (tick && !twr) m_time[i] = m_time[i] + 64'd1;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict the response, clock, update the model, compare.
  task automatic cycle();
    logic [32:0] exp_r [2];
    bit exp_v, exp_rd;
    for (int i = 0; i < 2; i++) exp_r[i] = model_read(i, req_addr);
    exp_v  = req_valid && !rst;
    exp_rd = !req_we;
    @(posedge clk);
    model_update();
    #1;
    chk("rsp_valid[0]", 64'(rsp_valid_a), 64'(exp_v));
    chk("rsp_valid[1]", 64'(rsp_valid_b), 64'(exp_v));
    if (exp_v) begin
      chk("rsp_err[0]", 64'(rsp_err_a), 64'(exp_r[0][32]));
      chk("rsp_err[1]", 64'(rsp_err_b), 64'(exp_r[1][32]));
      if (exp_rd) begin
        chk("rsp_rdata[0]", 64'(rsp_rdata_a), 64'(exp_r[0][31:0]));
        chk("rsp_rdata[1]", 64'(rsp_rdata_b), 64'(exp_r[1][31:0]));
      end
    end
    chk("msip[0]", 64'(msip_a), 64'({m_msip[0][1], m_msip[0][0]}));
    chk("mtip[0]", 64'(mtip_a), 64'({m_mtip[0][1], m_mtip[0][0]}));
    chk("msip[1]", 64'(msip_b), 64'(m_msip[1][0]));
    chk("mtip[1]", 64'(mtip_b), 64'(m_mtip[1][0]));
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    cycle();
  endtask

  task automatic rd(logic [15:0] off);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'(off); req_be = 4'h0;
    cycle();
  endtask

  task automatic wr(logic [15:0] off, logic [31:0] d, logic [3:0] be);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'(off); req_wdata = d; req_be = be;
    cycle();
  endtask

  logic [15:0] offs [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                             16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'hBFF0, 16'h1236};

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = BASE;
    req_be = 4'h0; req_wdata = '0; dbg_halt = 1'b0;

    // Reset state.
    repeat (3) cycle();
    chk("reset_rdata[0]", 64'(rsp_rdata_a), 64'h0);
    chk("reset_err[0]", 64'(rsp_err_a), 64'h0);
    rst = 1'b0;

    // Read mtime straight out of reset.
    rd(16'hBFF8);
    rd(16'hBFFC);

    // Prescaler run, then a 10-cycle halt with reads of the frozen count.
    repeat (9) idle();
    rd(16'hBFF8);
    dbg_halt = 1'b1;
    repeat (10) rd(16'hBFF8);
    dbg_halt = 1'b0;
    repeat (6) rd(16'hBFF8);

    // Low-to-high carry.
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    idle();
    idle();
    rd(16'hBFF8);
    chk("carry_lo[1]", 64'(rsp_rdata_b), 64'h0);
    rd(16'hBFFC);
    chk("carry_hi[1]", 64'(rsp_rdata_b), 64'h1);

    // Software write beats a carrying tick.
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'h1234_5678, 4'hF);
    rd(16'hBFFC);
    chk("nocarry_hi[1]", 64'(rsp_rdata_b), 64'h0);
    rd(16'hBFF8);
    chk("nocarry_lo[1]", 64'(rsp_rdata_b), 64'h1234_5679);

    // Unmapped hart slot.
    rd(16'h0008);
    chk("err_0008[0]", 64'(rsp_err_a), 64'h1);
    chk("rdata_0008[0]", 64'(rsp_rdata_a), 64'h0);

    // Partial byte write over all-ones mtimecmp[0] low.
    wr(16'h4000, 32'hAABB_CCDD, 4'b0010);
    rd(16'h4000);
    chk("be_merge[0]", 64'(rsp_rdata_a), 64'hFFFF_CCFF);

    // msip set, no-op write, clear.
    wr(16'h0000, 32'h1, 4'h1);
    wr(16'h0004, 32'h1, 4'h0);
    wr(16'h0004, 32'h3, 4'h1);
    rd(16'h0004);
    wr(16'h0004, 32'h0, 4'h1);

    // mtimecmp[1] = 50 with mtime = 40; watch mtip[1] rise.
    wr(16'h400C, 32'h0, 4'hF);
    wr(16'h4008, 32'd50, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'd40, 4'hF);
    n = 0;
    while (m_time[0] < 64'd52 && n < 400) begin
      idle();
      n++;
    end
    chk("mtip_wait_bound", 64'(n < 400), 64'h1);
    chk("mtip1_high[0]", 64'(mtip_a[1]), 64'h1);
    chk("mtip0_low[0]", 64'(mtip_a[0]), 64'h0);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      dbg_halt  = ($urandom_range(7) == 0);
      req_valid = ($urandom_range(3) != 0);
      req_we    = $urandom_range(1);
      req_addr  = BASE + 32'(offs[$urandom_range(11)]);
      req_be    = 4'($urandom_range(15));
      req_wdata = (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | 32'($urandom_range(40));
      cycle();
    end
    dbg_halt = 1'b0;

    // Reset during a write: no response, write discarded.
    rst = 1'b1;
    wr(16'h0000, 32'h1, 4'h1);
    chk("rst_no_rsp[0]", 64'(rsp_valid_a), 64'h0);
    rst = 1'b0;
    rd(16'h0000);
    chk("rst_msip_rd[0]", 64'(rsp_rdata_a), 64'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_multi.md
# clint_multi

Parametrised core-local interruptor for the RISC-V CPU. It replaces the single-hart timer and software-interrupt logic inside the unified memory block with a standalone MMIO slave. Features:
- 64-bit `mtime` with correct carry, a clock prescaler and a debug freeze;
- per-hart `mtimecmp` and `msip`;
- byte-enable writes and a registered one-cycle read response.

It sits on the data-memory MMIO decode path, beside the UART, and drives `msip`/`mtip` into each hart's CSR unit.

## Interface
Parameters:
- `NUM_HARTS`, 1 — number of harts, 1..8.
- `TICK_DIV`, 1 — clock cycles per `mtime` increment, ≥1.
- `BASE_ADDR`, 32'h0200_0000 — CLINT base address, 64 KiB aligned.

Ports (clock and reset first):
- `clk` in 1 — single clock; reset is synchronous and active-high.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — access request this cycle. The requester drops it while stalled.
- `req_we` in 1 — 1 = write, 0 = read.
- `req_addr` in 32 — byte address. Bits [1:0] are ignored.
- `req_be` in 4 — byte enables for writes.
- `req_wdata` in 32 — write data.
- `rsp_valid` out 1 — response strobe, one cycle after the request.
- `rsp_rdata` out 32 — read data. Valid when `rsp_valid` is high and the request was a read.
- `rsp_err` out 1 — the address is unmapped or out of range.
- `dbg_halt` in 1 — freezes `mtime` and the prescaler.
- `msip` out NUM_HARTS — software interrupt pending, one bit per hart.
- `mtip` out NUM_HARTS — timer interrupt pending, one bit per hart.

## Operation
Register map, word offsets from `BASE_ADDR`. Every register is R/W.
- `msip[h]`: offset 0x0000 + 4h.
  - Only bit 0 is implemented. A write takes `wdata[0]` when `be[0]` is set.
  - Reads return `{31'b0, msip[h]}`.
- `mtimecmp[h]`: low word at 0x4000 + 8h, high word at 0x4004 + 8h.
- `mtime`: low word at 0xBFF8, high word at 0xBFFC.
- Any other offset inside the 64 KiB window, or a hart index ≥ NUM_HARTS:
  - writes are ignored;
  - reads return 0 with `rsp_err` = 1.
- Addresses outside the window must not be presented. Decode ownership belongs to the parent.

Writes:
- Each byte lane whose enable is set is updated; other lanes keep their value.
- `req_be` = 0 is a legal no-op. It still produces `rsp_valid`.

Prescaler:
- A counter `div_cnt` of width clog2(TICK_DIV) or 1.
- When `dbg_halt` = 0, `div_cnt` increments. When it reaches TICK_DIV-1 it wraps to 0 and asserts `tick`.
- When TICK_DIV = 1, `tick` is high every cycle that is not halted.

`mtime` counter:
- On `tick`, the full 64 bits increment.
- Carry from the low word into the high word happens in the same cycle (0x0000_0000_FFFF_FFFF → 0x0000_0001_0000_0000).
- 0xFFFF_FFFF_FFFF_FFFF wraps to 0.

Simultaneous events:
- A software write to either `mtime` word in the same cycle as `tick` wins. That cycle has no increment and no carry, including carry into the unwritten word.
- A read in the same cycle as `tick` returns the pre-increment value.

`mtip` generation:
- Each cycle, `mtip[h]` is registered from an unsigned 64-bit compare of the current `mtime` against `mtimecmp[h]` (`mtime` ≥ `mtimecmp[h]`).
- `mtip[h]` therefore lags any register change by one cycle.

Reset values:
- `mtime` = 0, `div_cnt` = 0, every `msip` = 0.
- Every `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so `mtip` stays 0 out of reset.
- `mtip` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.

Reset mid-operation:
- Reset overrides every pending write and the response pipeline.
- There is no `rsp_valid` in the cycle after reset is asserted.

## Timing
- No backpressure. Every cycle with `req_valid` high is accepted.
- Cycle N: request sampled, writes committed at the clock edge.
- Cycle N+1: `rsp_valid`, `rsp_rdata` and `rsp_err` are driven for exactly one cycle.
- Back-to-back requests produce back-to-back responses.
- A read at N+1 of a register written at N returns the new value.
- `mtip` reflects a `mtimecmp` write at N from cycle N+2.

## Structure
- Shared package (`csr_defs`) holds:
  - `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`;
  - hart stride constants;
  - a `be_merge` function (byte-lane merge), reused by the RAM path.
- Sub-module `clint_timebase`: prescaler plus 64-bit `mtime` counter with the write port and halt.
- The top level holds the decode, the per-hart register arrays, the compare and the response register.

## Test plan
1. Reset → `mtip` = 0, `msip` = 0. A read at 0xBFF8 right after reset returns a small count with `rsp_err` = 0 one cycle later.
2. TICK_DIV = 4, with `dbg_halt` held for 10 cycles mid-run → `mtime` advances by 1 per 4 cycles and is frozen during the halt.
3. Write `mtime` = 0x0000_0000_FFFF_FFFE with TICK_DIV = 1 → two cycles later, reads give low = 0x0000_0000 and high = 0x0000_0001.
4. NUM_HARTS = 2: write `mtimecmp[1]` = 50 with `mtime` at 40 → `mtip[1]` rises one cycle after `mtime` reaches 50, and `mtip[0]` stays 0.
5. Write 0xAABBCCDD to `mtimecmp[0]` low with `be` = 4'b0010 over 0xFFFF_FFFF → readback is 0xFFFF_CCFF.
6. Read at 0x0008 with NUM_HARTS = 2, and write `mtime` low in the same cycle as a carry tick → `rsp_err` = 1 with `rdata` = 0, and the written value holds with no carry into the high word.
